// File: rtl/multichannel_frequency_reporter.sv
// multichannel_frequency_reporter: formats channel results as ASCII decimal text lines over a byte handshake
module multichannel_frequency_reporter #(
  parameter int NUMBER_OF_CHANNELS = 2,
  parameter int RESULT_WIDTH = 24,
  parameter int NUMBER_OF_DIGITS = 8,
  parameter int DECIMAL_PLACES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic only_on_change,
  input  logic [NUMBER_OF_CHANNELS*RESULT_WIDTH-1:0] results,
  output logic [7:0] byte_out,
  output logic byte_valid,
  input  logic byte_ready,
  output logic busy,
  output logic [15:0] lines_sent,
  output logic [15:0] lines_skipped
);
  localparam int N = NUMBER_OF_CHANNELS;
  localparam int RW = RESULT_WIDTH;
  localparam int ND = NUMBER_OF_DIGITS;
  localparam int DP = DECIMAL_PLACES;
  localparam int BD = (RW * 302 + 999) / 1000 + 1;
  localparam int BDW = BD > ND ? BD : ND;
  localparam int L = ND + (DP > 0 ? 1 : 0);
  localparam int DOT = ND - DP;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int KW = $clog2(BDW);
  typedef enum logic [2:0] {IDLE, LATCH, CONVERT, EMIT, SEPARATOR, CR, LF} state_t;
  state_t state, state_n;
  logic [N*RW-1:0] snap, last_snap;
  logic last_valid;
  logic [RW-1:0] snap_ch [N];
  logic [CW-1:0] ch, ch_n;
  logic [RW-1:0] bin;
  logic [BDW*4-1:0] bcd, adj;
  logic [3:0] dig [BDW];
  logic [BDW-1:0] lz;
  logic [5:0] cnt;
  logic [3:0] pos, dpos;
  logic [KW-1:0] k;
  logic skip, load, ovf, blank, is_dot;
  logic [7:0] ch_char;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign snap_ch[i] = snap[i*RW +: RW];
  end
  for (genvar i = 0; i < BDW; i++) begin : g_dig
    assign dig[i] = bcd[i*4 +: 4];
    assign adj[i*4 +: 4] = dig[i] >= 4'd5 ? dig[i] + 4'd3 : dig[i];
  end
  assign skip = only_on_change && last_valid && snap == last_snap;
  assign load = state == LATCH || (state == SEPARATOR && byte_ready);
  assign ch_n = state == LATCH ? '0 : ch + 1'b1;
  assign ovf = BDW > ND ? |(bcd >> (ND * 4)) : 1'b0;
  assign is_dot = DP > 0 && pos == 4'(DOT);
  assign dpos = (DP > 0 && pos > 4'(DOT)) ? pos - 4'd1 : pos;
  assign k = KW'(4'(ND - 1) - dpos);
  assign blank = lz[k] && k > KW'(DP);
  assign ch_char = is_dot ? 8'h2E : ovf ? 8'h2D : blank ? 8'h20 : {4'h3, dig[k]};
  assign busy = state != IDLE;
  // leading-zero flags: lz[i] set when every digit from the top displayed one down to i is zero
  always_comb begin
    lz = '0;
    lz[ND-1] = dig[ND-1] == 4'd0;
    for (int i = ND - 2; i >= 0; i--) lz[i] = lz[i+1] && dig[i] == 4'd0;
  end
  // next state and byte presented to the sink
  always_comb begin
    state_n = state;
    byte_valid = 1'b0;
    byte_out = 8'h00;
    case (state)
      IDLE: state_n = start ? LATCH : IDLE;
      LATCH: state_n = skip ? IDLE : CONVERT;
      CONVERT: state_n = cnt == 6'(RW - 1) ? EMIT : CONVERT;
      EMIT: begin
        byte_valid = 1'b1;
        byte_out = ch_char;
        if (byte_ready && pos == 4'(L - 1)) state_n = ch == CW'(N - 1) ? CR : SEPARATOR;
      end
      SEPARATOR: begin
        byte_valid = 1'b1;
        byte_out = 8'h20;
        state_n = byte_ready ? CONVERT : SEPARATOR;
      end
      CR: begin
        byte_valid = 1'b1;
        byte_out = 8'h0D;
        state_n = byte_ready ? LF : CR;
      end
      LF: begin
        byte_valid = 1'b1;
        byte_out = 8'h0A;
        state_n = byte_ready ? IDLE : LF;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  // snapshot, change-detection memory and line counters
  always_ff @(posedge clock) begin
    if (reset) begin
      last_valid <= 1'b0;
      lines_sent <= '0;
      lines_skipped <= '0;
    end else begin
      if (state == IDLE && start) snap <= results;
      if (state == LATCH && skip) lines_skipped <= lines_skipped + 16'd1;
      if (state == LF && byte_ready) begin
        lines_sent <= lines_sent + 16'd1;
        last_snap <= snap;
        last_valid <= 1'b1;
      end
    end
  end
  // serial double-dabble of the selected channel and character position tracking
  always_ff @(posedge clock) begin
    if (load) begin
      ch <= ch_n;
      bin <= snap_ch[ch_n];
      bcd <= '0;
      cnt <= '0;
    end else if (state == CONVERT) begin
      bcd <= {adj[BDW*4-2:0], bin[RW-1]};
      bin <= bin << 1;
      cnt <= cnt + 6'd1;
    end
    pos <= state == CONVERT ? 4'd0 : (state == EMIT && byte_ready) ? pos + 4'd1 : pos;
  end
endmodule
